// File: rtl/vector_pkg.sv
// Shared types and defaults for the vector issue sequencer.
package vector_pkg;

    localparam int N_DEF     = 24;
    localparam int ELEMS_DEF = 16;
    localparam int LANES_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } vseq_state_t;

    localparam logic [N_DEF-1:0] VNOP = '0;

endpackage

// File: rtl/vector_issue_sequencer_lane_mask_gen.sv
// Combinational lane-mask and last-beat generator for one beat starting at ElemBase.
module lane_mask_gen #(
    parameter int LANES = 4,
    parameter int IDXW  = 4
) (
    input  logic [IDXW:0]    ElemBase,
    input  logic [IDXW:0]    vl,
    output logic [LANES-1:0] LaneMask,
    output logic             Last
);

    // One extra bit so ElemBase + LANES can never wrap.
    logic [IDXW+1:0] base_ext;
    logic [IDXW+1:0] vl_ext;

    assign base_ext = {1'b0, ElemBase};
    assign vl_ext   = {1'b0, vl};

    always_comb begin
        LaneMask = '0;
        for (int i = 0; i < LANES; i++) begin
            LaneMask[i] = (base_ext + (IDXW+2)'(i)) < vl_ext;
        end
        Last = (base_ext + (IDXW+2)'(LANES)) >= vl_ext;
    end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Issues a decoded vector instruction to execute as LANES-wide beats and freezes F/D meanwhile.
// Optional performance counters are enabled with the VSEQ_PERF_EN macro.
module vector_issue_sequencer
    import vector_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ELEMS = ELEMS_DEF,
    parameter int LANES = LANES_DEF,
    parameter int IDXW  = $clog2(ELEMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     InstrD_vector,
    input  logic [IDXW:0]    VLD,
    input  logic             ReadyE,
    input  logic             FlushE,
    output logic [N-1:0]     InstrE_vector,
    output logic [IDXW-1:0]  ElemBaseE,
    output logic [LANES-1:0] LaneMaskE,
    output logic             ValidE,
    output logic             LastE,
    output logic             StallV,
    output logic             state_dbg
`ifdef VSEQ_PERF_EN
    ,
    output logic [31:0]      BeatCount,
    output logic [31:0]      StallCount
`endif
);

    vseq_state_t      state_q, state_d;
    logic [N-1:0]     instr_q, instr_d;
    logic [IDXW:0]    vl_q, vl_d;
    logic [IDXW:0]    base_q, base_d;
    logic [IDXW:0]    vl_in;
    logic             valid_q, valid_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic             last_q, last_d;
    logic             accept;
    logic             load_ok;

    assign vl_in   = (VLD > (IDXW+1)'(ELEMS)) ? (IDXW+1)'(ELEMS) : VLD;
    assign load_ok = (InstrD_vector != N'(VNOP)) && (vl_in != '0);
    assign accept  = valid_q && ReadyE;

    // Mask/last are computed for the *next* beat so they can be registered.
    lane_mask_gen #(
        .LANES (LANES),
        .IDXW  (IDXW)
    ) u_mask (
        .ElemBase (base_d),
        .vl       (vl_d),
        .LaneMask (mask_d),
        .Last     (last_d)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        vl_d    = vl_q;
        base_d  = base_q;
        valid_d = valid_q;
        if (FlushE) begin
            state_d = IDLE;
            valid_d = 1'b0;
            base_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_ok) begin
                        state_d = ISSUE;
                        instr_d = InstrD_vector;
                        vl_d    = vl_in;
                        base_d  = '0;
                        valid_d = 1'b1;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (last_q) begin
                            base_d = '0;
                            if (load_ok) begin
                                instr_d = InstrD_vector;
                                vl_d    = vl_in;
                            end else begin
                                state_d = IDLE;
                                valid_d = 1'b0;
                            end
                        end else begin
                            base_d = base_q + (IDXW+1)'(LANES);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            instr_q <= '0;
            vl_q    <= '0;
            base_q  <= '0;
            valid_q <= 1'b0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            vl_q    <= vl_d;
            base_q  <= base_d;
            valid_q <= valid_d;
            mask_q  <= valid_d ? mask_d : '0;
            last_q  <= valid_d && last_d;
        end
    end

    assign InstrE_vector = instr_q;
    assign ElemBaseE     = base_q[IDXW-1:0];
    assign LaneMaskE     = mask_q;
    assign ValidE        = valid_q;
    assign LastE         = last_q;
    assign StallV        = (state_q == ISSUE) && !(valid_q && last_q && ReadyE);
    assign state_dbg     = (state_q == ISSUE);

`ifdef VSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            BeatCount  <= '0;
            StallCount <= '0;
        end else begin
            if (accept) BeatCount  <= BeatCount + 32'd1;
            if (StallV) StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule
